// File: rtl/branch_redirect_controller.sv
// Branch/jump redirect controller: offers the resolved target PC to fetch over valid/ready,
// squashes wrong-path segments, and counts accepted redirects.
module branch_redirect_controller #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_valid,
   input  logic            mem_branch,
   input  logic            mem_jump,
   input  logic            mem_take,
   input  logic [XLEN-1:0] mem_target,
   input  logic            redirect_ready,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic            flush_ex_mem,
   output logic            misalign_err,
   output logic [31:0]     taken_count
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACCEPT = 2'd1,
      FLUSH       = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

   state_t     state;
   logic [2:0] flush_cnt;
   logic       misalign_pend;
   logic       take;
   logic       accept;
   logic       unused_target_lsb;

   assign take              = mem_valid & (mem_jump | (mem_branch & mem_take));
   assign accept            = redirect_valid & redirect_ready;
   assign unused_target_lsb = mem_target[0];

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         flush_cnt      <= 3'd0;
         misalign_pend  <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_if_id    <= 1'b0;
         flush_id_ex    <= 1'b0;
         flush_ex_mem   <= 1'b0;
         misalign_err   <= 1'b0;
         taken_count    <= 32'd0;
      end else begin
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               // EX/MEM contents are only trusted here; elsewhere they are wrong-path or bubbles
               if (take) begin
                  state          <= WAIT_ACCEPT;
                  redirect_pc    <= {mem_target[XLEN-1:1], 1'b0};
                  misalign_pend  <= mem_target[1];
                  redirect_valid <= 1'b1;
                  flush_if_id    <= 1'b1;
                  flush_id_ex    <= 1'b1;
                  flush_ex_mem   <= 1'b1;
               end
            end
            WAIT_ACCEPT: begin
               if (accept) begin
                  taken_count    <= sat_inc(taken_count);
                  misalign_err   <= misalign_pend;
                  redirect_valid <= 1'b0;
                  flush_id_ex    <= 1'b0;
                  flush_ex_mem   <= 1'b0;
                  if (FLUSH_INIT == 3'd0) begin
                     state       <= IDLE;
                     flush_if_id <= 1'b0;
                  end else begin
                     state       <= FLUSH;
                     flush_cnt   <= FLUSH_INIT;
                     flush_if_id <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (flush_cnt <= 3'd1) begin
                  state       <= IDLE;
                  flush_cnt   <= 3'd0;
                  flush_if_id <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 3'd1;
               end
            end
            default: begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               flush_if_id    <= 1'b0;
               flush_id_ex    <= 1'b0;
               flush_ex_mem   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Bench for branch_redirect_controller: two instances (FLUSH_CYCLES=1 and 0) share stimulus and
// are checked every cycle against a cycle-level behavioural model plus literal expectations.
module tb_branch_redirect_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, mem_branch, mem_jump, mem_take, redirect_ready;
   logic [31:0] mem_target;

   logic        a_valid, a_fif, a_fid, a_fem, a_mis;
   logic [31:0] a_pc, a_cnt;
   logic        b_valid, b_fif, b_fid, b_fem, b_mis;
   logic [31:0] b_pc, b_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_redirect_controller #(.XLEN(32), .FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_jump(mem_jump),
      .mem_take(mem_take), .mem_target(mem_target), .redirect_ready(redirect_ready),
      .redirect_valid(a_valid), .redirect_pc(a_pc),
      .flush_if_id(a_fif), .flush_id_ex(a_fid), .flush_ex_mem(a_fem),
      .misalign_err(a_mis), .taken_count(a_cnt)
   );

   branch_redirect_controller #(.XLEN(32), .FLUSH_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_jump(mem_jump),
      .mem_take(mem_take), .mem_target(mem_target), .redirect_ready(redirect_ready),
      .redirect_valid(b_valid), .redirect_pc(b_pc),
      .flush_if_id(b_fif), .flush_id_ex(b_fid), .flush_ex_mem(b_fem),
      .misalign_err(b_mis), .taken_count(b_cnt)
   );

   // Model: index 0 tracks dut_a (FLUSH_CYCLES=1), index 1 tracks dut_b (FLUSH_CYCLES=0)
   logic        m_offer [2];
   int          m_left  [2];
   logic [31:0] m_pc    [2];
   logic        m_pend  [2];
   logic        m_mis   [2];
   longint      m_acc   [2];
   longint      offset_b;

   function automatic int fc_of(int k);
      return (k == 0) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_offer[k] = 1'b0; m_left[k] = 0; m_pc[k] = 32'd0;
            m_pend[k]  = 1'b0; m_mis[k]  = 1'b0; m_acc[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_mis[k] = 1'b0;
            if (m_offer[k]) begin
               if (redirect_ready) begin
                  m_offer[k] = 1'b0;
                  m_acc[k]   = m_acc[k] + 1;
                  m_mis[k]   = m_pend[k];
                  m_left[k]  = fc_of(k);
               end
            end else if (m_left[k] > 0) begin
               m_left[k] = m_left[k] - 1;
            end else if (mem_valid && (mem_jump || (mem_branch && mem_take))) begin
               m_offer[k] = 1'b1;
               m_pc[k]    = {mem_target[31:1], 1'b0};
               m_pend[k]  = mem_target[1];
            end
         end
      end
   end

   function automatic logic [31:0] exp_cnt(int k);
      longint s;
      s = m_acc[k] + ((k == 1) ? offset_b : 64'd0);
      return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   task automatic chk1(input string nm, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b expected=%b t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic cmp_one(input string t, input int k, input logic v, input logic [31:0] pc,
                          input logic fif, input logic fid, input logic fem, input logic mis,
                          input logic [31:0] cnt);
      chk1({t, ".valid"}, v, m_offer[k]);
      chk32({t, ".pc"}, pc, m_pc[k]);
      chk1({t, ".flush_if_id"}, fif, m_offer[k] | (m_left[k] > 0));
      chk1({t, ".flush_id_ex"}, fid, m_offer[k]);
      chk1({t, ".flush_ex_mem"}, fem, m_offer[k]);
      chk1({t, ".misalign"}, mis, m_mis[k]);
      chk32({t, ".count"}, cnt, exp_cnt(k));
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         cmp_one("a", 0, a_valid, a_pc, a_fif, a_fid, a_fem, a_mis, a_cnt);
         cmp_one("b", 1, b_valid, b_pc, b_fif, b_fid, b_fem, b_mis, b_cnt);
      end
   endtask

   task automatic drive(input logic v, input logic br, input logic jp, input logic tk,
                        input logic [31:0] tgt);
      mem_valid  = v;
      mem_branch = br;
      mem_jump   = jp;
      mem_take   = tk;
      mem_target = tgt;
   endtask

   initial begin
      rst_n = 1'b0;
      offset_b = 0;
      redirect_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         redirect_ready = 1'($urandom);
         @(negedge clk);
         chk1("rst.valid", a_valid, 1'b0);
         chk1("rst.flush", a_fif | a_fid | a_fem | b_fif | b_fid | b_fem, 1'b0);
      end
      chk32("rst.count", a_cnt, 32'd0);
      chk32("rst.pc", b_pc, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      redirect_ready = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      chk1("idle.valid", a_valid, 1'b0);
      chk32("idle.count", a_cnt, 32'd0);

      // Taken branch, ready=1
      redirect_ready = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0104);
      step();
      chk1("br.n1.valid", a_valid, 1'b1);
      chk32("br.n1.pc", a_pc, 32'h0000_0104);
      chk1("br.n1.flush_all", a_fif & a_fid & a_fem, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      chk1("br.n2.fif", a_fif, 1'b1);
      chk1("br.n2.fid_fem", a_fid | a_fem | a_valid, 1'b0);
      chk32("br.n2.count", a_cnt, 32'd1);
      chk1("br.n2.b_fif", b_fif, 1'b0);
      step();
      chk1("br.n3.fif", a_fif, 1'b0);

      // Not-taken branch, then jump with mem_valid=0
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0800);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0900);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      chk1("nt.valid", a_valid | a_fif | b_valid, 1'b0);
      chk32("nt.count", a_cnt, 32'd1);

      // Backpressure: jalr to 0x203 with ready low three cycles
      redirect_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0203);
      step();
      chk1("bp.n1.valid", a_valid, 1'b1);
      chk32("bp.n1.pc", a_pc, 32'h0000_0202);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0500);
      step();
      chk32("bp.n3.pc", a_pc, 32'h0000_0202);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      step();
      chk1("bp.n4.valid", a_valid & a_fem, 1'b1);
      chk32("bp.n4.pc", b_pc, 32'h0000_0202);
      redirect_ready = 1'b1;
      step();
      chk1("bp.n5.mis", a_mis, 1'b1);
      chk32("bp.n5.count", a_cnt, 32'd2);
      chk1("bp.n5.valid", a_valid, 1'b0);
      step();
      chk1("bp.n6.mis", a_mis, 1'b0);

      // Asynchronous reset while a redirect is pending
      redirect_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
      step();
      chk1("rw.valid", a_valid, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk1("rw.valid_drop", a_valid | b_valid, 1'b0);
      chk1("rw.flush_drop", a_fif | a_fid | a_fem, 1'b0);
      chk32("rw.count", a_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      redirect_ready = 1'b1;
      step();

      // Saturation on the FLUSH_CYCLES=0 instance
      #2;
      force dut_b.taken_count = 32'hFFFF_FFFE;
      offset_b = 64'h0000_0000_FFFF_FFFE;
      #1;
      release dut_b.taken_count;
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000 + 32'(i * 4));
         step();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
         step();
         if (i == 0) begin
            chk1("sat.b.no_flush", b_fif | b_valid, 1'b0);
            chk32("sat.b.count1", b_cnt, 32'hFFFF_FFFF);
         end
         step();
      end
      chk32("sat.b.count", b_cnt, 32'hFFFF_FFFF);
      chk32("sat.a.count", a_cnt, 32'd3);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
